// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control, increment/branch/jump/stall/halt.
// Optional return stack for Call/Ret is built only when CALL_STACK_EN is defined.
module pc_sequencer #(
    parameter int unsigned D      = 12,
    parameter int unsigned SDEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         Branch,
    input  logic         Jump,
    input  logic         Call,
    input  logic         Ret,
    input  logic         Halt,
    input  logic [D-1:0] Target,
    output logic [D-1:0] ProgCtr,
    output logic         Running,
    output logic         Done,
    output logic         StackErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [D-1:0] r_pc;
    logic         r_running;
    logic         r_done;

    logic [D-1:0] w_pc_inc;
    logic [D-1:0] w_pc_br;
    logic [D-1:0] w_pc_next;

    // Modulo-2^D arithmetic falls out of the D-bit adders.
    assign w_pc_inc = r_pc + D'(1);
    assign w_pc_br  = r_pc + Target;

`ifdef CALL_STACK_EN
    localparam int unsigned SPW = $clog2(SDEPTH + 1);
    localparam int unsigned AW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [D-1:0]   r_stack [SDEPTH];
    logic [SPW-1:0] r_sp;
    logic           r_stack_err;

    logic           w_start;
    logic           w_adv;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_push;
    logic           w_stack_fault;
    logic [AW-1:0]  w_top_idx;
    logic [AW-1:0]  w_push_idx;

    assign w_start    = (r_state != S_RUN) && Start;
    assign w_adv      = (r_state == S_RUN) && !Halt && !Stall;
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == SPW'(SDEPTH));
    assign w_pop      = w_adv && Ret && !w_empty;
    assign w_push     = w_adv && !Ret && Call && !w_full;
    assign w_top_idx  = AW'(r_sp - SPW'(1));
    assign w_push_idx = AW'(r_sp);

    // Ret beats Call beats Jump beats Branch; faulting stack ops still move the PC.
    always_comb begin
        w_pc_next     = w_pc_inc;
        w_stack_fault = 1'b0;
        if (Ret) begin
            if (w_empty) begin
                w_stack_fault = 1'b1;
            end else begin
                w_pc_next = r_stack[w_top_idx];
            end
        end else if (Call) begin
            w_pc_next     = Target;
            w_stack_fault = w_full;
        end else if (Jump) begin
            w_pc_next = Target;
        end else if (Branch) begin
            w_pc_next = w_pc_br;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else if (w_start) begin
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_sp <= r_sp - SPW'(1);
            end else if (w_push) begin
                r_sp <= r_sp + SPW'(1);
            end
            if (w_adv && w_stack_fault) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    // Return-address storage needs no reset: entries are only read below r_sp.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign StackErr = r_stack_err;
`else
    logic w_unused_stack_inputs;

    assign w_unused_stack_inputs = Call | Ret | (SDEPTH == 0);

    always_comb begin
        w_pc_next = w_pc_inc;
        if (Jump) begin
            w_pc_next = Target;
        end else if (Branch) begin
            w_pc_next = w_pc_br;
        end
    end

    assign StackErr = 1'b0;
`endif

    // Control FSM; Halt outranks Stall, Start is only honoured outside RUN.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state   <= S_RUN;
                        r_pc      <= '0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (Halt) begin
                        r_state   <= S_DONE;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (!Stall) begin
                        r_pc <= w_pc_next;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_pc      <= '0;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr = r_pc;
    assign Running = r_running;
    assign Done    = r_done;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized run
// against a queue-based behavioural model.
module tb_pc_sequencer;

    localparam int D      = 12;
    localparam int SDEPTH = 4;
    localparam int PCMOD  = 1 << D;

    logic         Clk    = 1'b0;
    logic         Reset  = 1'b0;
    logic         Start  = 1'b0;
    logic         Stall  = 1'b0;
    logic         Branch = 1'b0;
    logic         Jump   = 1'b0;
    logic         Call   = 1'b0;
    logic         Ret    = 1'b0;
    logic         Halt   = 1'b0;
    logic [D-1:0] Target = '0;
    logic [D-1:0] ProgCtr;
    logic         Running;
    logic         Done;
    logic         StackErr;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_pc   = 0;
    bit m_run  = 1'b0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;
    int m_stk[$];

    pc_sequencer #(.D(D), .SDEPTH(SDEPTH)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Stall   (Stall),
        .Branch  (Branch),
        .Jump    (Jump),
        .Call    (Call),
        .Ret     (Ret),
        .Halt    (Halt),
        .Target  (Target),
        .ProgCtr (ProgCtr),
        .Running (Running),
        .Done    (Done),
        .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_pc = 0; m_run = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_edge();
        if (!Reset) begin
            model_reset();
        end else if (!m_run) begin
            if (Start) begin
                m_run = 1'b1; m_done = 1'b0; m_pc = 0; m_err = 1'b0;
                m_stk.delete();
            end
        end else if (Halt) begin
            m_run = 1'b0; m_done = 1'b1;
        end else if (Stall) begin
            m_pc = m_pc;
`ifdef CALL_STACK_EN
        end else if (Ret) begin
            if (m_stk.size() == 0) begin
                m_pc = (m_pc + 1) % PCMOD; m_err = 1'b1;
            end else begin
                m_pc = m_stk.pop_back();
            end
        end else if (Call) begin
            if (m_stk.size() == SDEPTH) m_err = 1'b1;
            else m_stk.push_back((m_pc + 1) % PCMOD);
            m_pc = int'(Target);
`endif
        end else if (Jump) begin
            m_pc = int'(Target);
        end else if (Branch) begin
            m_pc = (((m_pc + int'($signed(Target))) % PCMOD) + PCMOD) % PCMOD;
        end else begin
            m_pc = (m_pc + 1) % PCMOD;
        end
    endtask

    task automatic clear_inputs();
        Start = 0; Stall = 0; Branch = 0; Jump = 0; Call = 0; Ret = 0; Halt = 0; Target = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start();
        clear_inputs(); Start = 1; tick(); Start = 0;
    endtask

    task automatic do_jump(input logic [D-1:0] t);
        clear_inputs(); Jump = 1; Target = t; tick(); clear_inputs();
    endtask

    task automatic test_reset();
        Reset = 0; clear_inputs();
        tick(); tick();
        checks++;
        if (ProgCtr !== 12'h000 || Running !== 1'b0 || Done !== 1'b0 || StackErr !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h run=%b done=%b err=%b expected pc=000 run=0 done=0 err=0",
                     ProgCtr, Running, Done, StackErr);
        end
        Reset = 1; tick();
        checks++;
        if (ProgCtr !== 12'h000 || Running !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold pc=%h run=%b expected pc=000 run=0", ProgCtr, Running);
        end
        do_start(); do_jump(12'h01A);
        checks++;
        if (ProgCtr !== 12'h01A) begin
            errors++; $display("FAIL reach_01a pc=%h expected 01a", ProgCtr);
        end
        #2 Reset = 0; model_reset(); #1;
        checks++;
        if (ProgCtr !== 12'h000 || Running !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pc=%h run=%b done=%b expected pc=000 run=0 done=0", ProgCtr, Running, Done);
        end
        tick(); Reset = 1; tick();
        do_start();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ProgCtr !== D'(i) || Running !== 1'b1) begin
                errors++;
                $display("FAIL seq_after_start step=%0d pc=%h run=%b expected pc=%h run=1", i, ProgCtr, Running, D'(i));
            end
            tick();
        end
    endtask

    task automatic test_branch_jump();
        do_jump(12'h010);
        Branch = 1; Target = 12'hFFB; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h00B) begin errors++; $display("FAIL branch_neg pc=%h expected 00b", ProgCtr); end
        do_jump(12'h010);
        Jump = 1; Target = 12'h200; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h200) begin errors++; $display("FAIL jump pc=%h expected 200", ProgCtr); end
        do_jump(12'h010);
        Branch = 1; Jump = 1; Target = 12'h040; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h040) begin errors++; $display("FAIL branch_jump pc=%h expected 040", ProgCtr); end
        do_jump(12'h002);
        Branch = 1; Target = 12'hFFF; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h001) begin errors++; $display("FAIL branch_minus1 pc=%h expected 001", ProgCtr); end
        Start = 1; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h002 || Running !== 1'b1) begin
            errors++; $display("FAIL start_in_run pc=%h run=%b expected pc=002 run=1", ProgCtr, Running);
        end
    endtask

    task automatic test_wrap_stall();
        do_jump(12'hFFF);
        checks++;
        if (ProgCtr !== 12'hFFF) begin errors++; $display("FAIL jump_fff pc=%h expected fff", ProgCtr); end
        tick();
        checks++;
        if (ProgCtr !== 12'h000) begin errors++; $display("FAIL wrap pc=%h expected 000", ProgCtr); end
        do_jump(12'h005);
        for (int i = 0; i < 3; i++) begin
            Stall = 1; Branch = 1; Target = 12'h123; tick();
            checks++;
            if (ProgCtr !== 12'h005) begin errors++; $display("FAIL stall cyc=%0d pc=%h expected 005", i, ProgCtr); end
        end
        clear_inputs(); tick();
        checks++;
        if (ProgCtr !== 12'h006) begin errors++; $display("FAIL after_stall pc=%h expected 006", ProgCtr); end
    endtask

    task automatic test_halt();
        do_jump(12'h033);
        Halt = 1; Stall = 1; tick(); clear_inputs();
        checks++;
        if (Done !== 1'b1 || Running !== 1'b0 || ProgCtr !== 12'h033) begin
            errors++;
            $display("FAIL halt pc=%h run=%b done=%b expected pc=033 run=0 done=1", ProgCtr, Running, Done);
        end
        for (int i = 0; i < 10; i++) begin
            Jump = 1; Branch = 1; Target = 12'h7A5; tick();
            checks++;
            if (ProgCtr !== 12'h033 || Done !== 1'b1) begin
                errors++; $display("FAIL done_frozen cyc=%0d pc=%h done=%b expected pc=033 done=1", i, ProgCtr, Done);
            end
        end
        do_start();
        checks++;
        if (ProgCtr !== 12'h000 || Done !== 1'b0 || Running !== 1'b1) begin
            errors++;
            $display("FAIL restart pc=%h run=%b done=%b expected pc=000 run=1 done=0", ProgCtr, Running, Done);
        end
    endtask

    task automatic test_call_ret();
        do_jump(12'h010);
        Call = 1; Target = 12'h100; tick(); clear_inputs();
`ifdef CALL_STACK_EN
        checks++;
        if (ProgCtr !== 12'h100) begin errors++; $display("FAIL call pc=%h expected 100", ProgCtr); end
        Ret = 1; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h011 || StackErr !== 1'b0) begin
            errors++; $display("FAIL ret pc=%h err=%b expected pc=011 err=0", ProgCtr, StackErr);
        end
        do_start();
        for (int i = 1; i <= 5; i++) begin
            Call = 1; Target = D'(i * 256); tick(); clear_inputs();
            checks++;
            if (StackErr !== (i == 5) || ProgCtr !== D'(i * 256)) begin
                errors++;
                $display("FAIL nested_call n=%0d pc=%h err=%b expected pc=%h err=%b", i, ProgCtr, StackErr, D'(i * 256), i == 5);
            end
        end
        Ret = 1; Call = 1; Target = 12'h777; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h301) begin errors++; $display("FAIL ret_over_call pc=%h expected 301", ProgCtr); end
        do_start();
        checks++;
        if (StackErr !== 1'b0) begin errors++; $display("FAIL err_clear err=%b expected 0", StackErr); end
        Ret = 1; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h001 || StackErr !== 1'b1) begin
            errors++; $display("FAIL ret_empty pc=%h err=%b expected pc=001 err=1", ProgCtr, StackErr);
        end
`else
        checks++;
        if (ProgCtr !== 12'h011 || StackErr !== 1'b0) begin
            errors++; $display("FAIL call_ignored pc=%h err=%b expected pc=011 err=0", ProgCtr, StackErr);
        end
        Ret = 1; Jump = 1; Target = 12'h0AB; tick(); clear_inputs();
        checks++;
        if (ProgCtr !== 12'h0AB || StackErr !== 1'b0) begin
            errors++; $display("FAIL ret_ignored pc=%h err=%b expected pc=0ab err=0", ProgCtr, StackErr);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            Start  = ($urandom_range(0, 9) == 0);
            Stall  = ($urandom_range(0, 5) == 0);
            Branch = ($urandom_range(0, 3) == 0);
            Jump   = ($urandom_range(0, 5) == 0);
            Call   = ($urandom_range(0, 6) == 0);
            Ret    = ($urandom_range(0, 6) == 0);
            Halt   = ($urandom_range(0, 39) == 0);
            Target = D'($urandom);
            tick();
            checks++;
            if (ProgCtr !== D'(m_pc) || Running !== m_run || Done !== m_done || StackErr !== m_err) begin
                errors++;
                $display("FAIL random cyc=%0d pc=%h run=%b done=%b err=%b expected pc=%h run=%b done=%b err=%b",
                         n, ProgCtr, Running, Done, StackErr, D'(m_pc), m_run, m_done, m_err);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_branch_jump();
        test_wrap_stall();
        test_halt();
        test_call_ret();
        do_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
